// File: rtl/mmc_spi_if.sv
// Host-side handshake bundle of the MMC SPI byte engine.
// The controller uses the master modport; the engine uses slave.
interface mmc_spi_if;
  logic       start;
  logic       speed;
  logic [7:0] wdata;
  logic       cs_assert;
  logic [7:0] rdata;
  logic       busy;
  logic       done;

  modport master (output start, speed, wdata, cs_assert,
                  input  rdata, busy, done);
  modport slave  (input  start, speed, wdata, cs_assert,
                  output rdata, busy, done);
endinterface

// File: rtl/mmc_spi.sv
// SPI mode-0 byte engine for an SD/MMC card: shifts one byte out MSB first
// while shifting one byte in, at a slow (init) or fast (data) SCLK rate.
module mmc_spi #(
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  mmc_spi_if.slave    host,
  output logic        mmc_cs,
  output logic        mmc_sclk,
  output logic        mmc_do,
  input  logic        mmc_di
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [7:0] SLOW = 8'(SLOW_DIV);
  localparam logic [7:0] FAST = 8'(FAST_DIV);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rdata_q, rdata_d;
  logic [2:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       do_q, do_d;
  logic       cs_q, cs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] div_sel;
  logic       cnt_zero;

  assign div_sel  = host.speed ? FAST : SLOW;
  assign cnt_zero = (cnt_q == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      cnt_q   <= 8'd0;
      sh_q    <= 8'd0;
      rdata_q <= 8'd0;
      bit_q   <= 3'd0;
      sclk_q  <= 1'b0;
      do_q    <= 1'b1;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      do_q    <= do_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host.start) state_d = LOW;
      LOW:     if (cnt_zero)   state_d = HIGH;
      HIGH:    if (cnt_zero)   state_d = (bit_q == 3'd0) ? IDLE : LOW;
      default: state_d = IDLE;
    endcase
  end

  // mmc_do is registered so it only moves with the falling SCLK edge, even
  // though the shift register already advances on the rising edge.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    do_d    = do_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        cs_d   = ~host.cs_assert;
        sclk_d = 1'b0;
        do_d   = 1'b1;
        if (host.start) begin
          div_d = div_sel;
          cnt_d = div_sel - 8'd1;
          sh_d  = host.wdata;
          bit_d = 3'd7;
          do_d  = host.wdata[7];
        end
      end
      LOW: begin
        if (cnt_zero) begin
          cnt_d  = div_q - 8'd1;
          sclk_d = 1'b1;
          sh_d   = {sh_q[6:0], mmc_di};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd0) begin
            rdata_d = sh_q;
            done_d  = 1'b1;
            do_d    = 1'b1;
          end else begin
            bit_d = bit_q - 3'd1;
            cnt_d = div_q - 8'd1;
            do_d  = sh_q[7];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign host.rdata = rdata_q;
  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign mmc_cs     = cs_q;
  assign mmc_sclk   = sclk_q;
  assign mmc_do     = do_q;

endmodule

// File: tb/tb_mmc_spi.sv
// Directed bench for mmc_spi with a small SD card model driving mmc_di
// on falling SCLK and recording command bits on rising SCLK.
module tb_mmc_spi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mmc_cs, mmc_sclk, mmc_do, mmc_di;

  mmc_spi_if hif();

  mmc_spi #(.SLOW_DIV(64), .FAST_DIV(2)) dut (
    .clk(clk), .reset(reset), .host(hif.slave),
    .mmc_cs(mmc_cs), .mmc_sclk(mmc_sclk), .mmc_do(mmc_do), .mmc_di(mmc_di)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Card model: response byte goes out MSB first, advancing on falling SCLK.
  logic [7:0] card_resp = 8'hFF;
  logic [2:0] nbit = 3'd0;
  always @(negedge mmc_sclk or posedge reset)
    if (reset) nbit <= 3'd0;
    else       nbit <= nbit + 3'd1;
  assign mmc_di = card_resp[3'd7 - nbit];

  logic [47:0] hist = 48'd0;
  always @(posedge mmc_sclk)
    if (!mmc_cs) hist <= {hist[46:0], mmc_do};

  // SCLK rise log, sampled on the falling clk edge.
  logic       sclk_prev = 1'b0;
  int         rises = 0;
  int         rise_last = 0, rise_prev = 0;
  logic [7:0] do_log = 8'd0;
  always @(negedge clk) begin
    if (mmc_sclk && !sclk_prev) begin
      rises     <= rises + 1;
      rise_prev <= rise_last;
      rise_last <= cyc;
      do_log    <= {do_log[6:0], mmc_do};
    end
    sclk_prev <= mmc_sclk;
  end

  localparam logic [47:0] CMD0 = 48'h40_00_00_00_00_95;

  int passed = 0;
  int total  = 0;
  int t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_byte(input logic spd, input logic [7:0] wd, input logic hold);
    @(negedge clk);
    hif.speed = spd;
    hif.wdata = wd;
    hif.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    if (!hold) hif.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (hif.done) begin
        at = cyc - t0;
        break;
      end
    end
  endtask

  task automatic slow_byte(input logic [7:0] wd, input logic [7:0] resp, input string tag);
    int at;
    card_resp = resp;
    start_byte(1'b0, wd, 1'b0);
    wait_done(1100, at);
    chk({tag, "_done"}, at, 1025);
  endtask

  initial begin
    int at, r0, dn, first, lowcnt;
    hif.start = 1'b0; hif.speed = 1'b0; hif.wdata = 8'h00; hif.cs_assert = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs", mmc_cs, 1'b1);
    chk("rst_sclk", mmc_sclk, 1'b0);
    chk("rst_do", mmc_do, 1'b1);
    chk("rst_busy", hif.busy, 1'b0);
    chk("rst_done", hif.done, 1'b0);
    chk("rst_rdata", hif.rdata, 8'h00);

    // Chip select follows cs_assert one cycle later while idle.
    hif.cs_assert = 1'b1;
    #1 chk("cs_before_edge", mmc_cs, 1'b1);
    @(posedge clk); #1;
    chk("cs_idle_1cyc", mmc_cs, 1'b0);

    // Fast transfer A5 out, 3C in.
    card_resp = 8'h3C;
    r0 = rises;
    start_byte(1'b1, 8'hA5, 1'b0);
    chk("fast_c1_busy", hif.busy, 1'b1);
    chk("fast_c1_sclk", mmc_sclk, 1'b0);
    chk("fast_c1_do", mmc_do, 1'b1);
    wait_done(60, at);
    chk("fast_done_cyc", at, 33);
    chk("fast_rdata", hif.rdata, 8'h3C);
    chk("fast_done_busy", hif.busy, 1'b0);
    chk("fast_done_sclk", mmc_sclk, 1'b0);
    chk("fast_done_do", mmc_do, 1'b1);
    chk("fast_rises", rises - r0, 8);
    chk("fast_period", rise_last - rise_prev, 4);
    chk("fast_last_rise", rise_last - t0, 31);
    chk("fast_do_bits", do_log, 8'hA5);
    @(negedge clk);
    chk("fast_done_pulse", hif.done, 1'b0);

    // Starts while busy are dropped.
    card_resp = 8'h96;
    start_byte(1'b1, 8'h5A, 1'b0);
    dn = 0; first = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (hif.done) begin
        dn++;
        if (first < 0) first = cyc - t0;
      end
      hif.start = ((cyc - t0) == 5) || ((cyc - t0) == 20);
    end
    hif.start = 1'b0;
    chk("ign_done_cnt", dn, 1);
    chk("ign_done_cyc", first, 33);
    chk("ign_rdata", hif.rdata, 8'h96);
    chk("ign_idle", hif.busy, 1'b0);

    // Start held through the done cycle chains a second byte.
    card_resp = 8'h81;
    start_byte(1'b1, 8'hC3, 1'b1);
    lowcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!hif.busy) lowcnt++;
      if (n == 33) chk("b2b_done", hif.done, 1'b1);
      if (n == 34) begin
        chk("b2b_busy_again", hif.busy, 1'b1);
        hif.start = 1'b0;
      end
    end
    chk("b2b_gap", lowcnt, 1);
    chk("b2b_rdata1", hif.rdata, 8'h81);
    t0 = t0 + 33;
    wait_done(60, at);
    chk("b2b_done2_cyc", at, 33);
    chk("b2b_rdata2", hif.rdata, 8'h81);

    // cs_assert dropped mid-byte takes effect only after the byte.
    card_resp = 8'h00;
    start_byte(1'b1, 8'h12, 1'b0);
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (n == 10) hif.cs_assert = 1'b0;
      if (n == 20) chk("csd_mid", mmc_cs, 1'b0);
      if (n == 33) chk("csd_done_cyc", mmc_cs, 1'b0);
      if (n == 34) chk("csd_after", mmc_cs, 1'b1);
    end
    chk("csd_rdata", hif.rdata, 8'h00);

    // Slow transfer FF out, 01 in.
    hif.cs_assert = 1'b1;
    repeat (2) @(negedge clk);
    card_resp = 8'h01;
    r0 = rises;
    start_byte(1'b0, 8'hFF, 1'b0);
    wait_done(1100, at);
    chk("slow_done_cyc", at, 1025);
    chk("slow_rdata", hif.rdata, 8'h01);
    chk("slow_rises", rises - r0, 8);
    chk("slow_period", rise_last - rise_prev, 128);
    chk("slow_last_rise", rise_last - t0, 961);
    chk("slow_do_bits", do_log, 8'hFF);

    // Card init: 10 dummy bytes deselected, then CMD0, then poll for R1.
    hif.cs_assert = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) slow_byte(8'hFF, 8'hFF, "init_ff");
    chk("init_ff_rdata", hif.rdata, 8'hFF);
    chk("init_cs_high", mmc_cs, 1'b1);
    hif.cs_assert = 1'b1;
    repeat (2) @(negedge clk);
    slow_byte(8'h40, 8'hFF, "cmd0_b0");
    for (int i = 0; i < 4; i++) slow_byte(8'h00, 8'hFF, "cmd0_arg");
    slow_byte(8'h95, 8'hFF, "cmd0_crc");
    chk("cmd0_seen", (hist == CMD0), 1'b1);
    slow_byte(8'hFF, (hist == CMD0) ? 8'h01 : 8'hFF, "r1_poll");
    chk("r1_rdata", hif.rdata, 8'h01);

    // Asynchronous reset in the middle of a byte.
    card_resp = 8'h5A;
    start_byte(1'b1, 8'hE7, 1'b0);
    while ((cyc - t0) < 19) @(negedge clk);
    chk("mid_sclk_hi", mmc_sclk, 1'b1);
    chk("mid_do_lo", mmc_do, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_cs", mmc_cs, 1'b1);
    chk("arst_sclk", mmc_sclk, 1'b0);
    chk("arst_do", mmc_do, 1'b1);
    chk("arst_busy", hif.busy, 1'b0);
    chk("arst_done", hif.done, 1'b0);
    chk("arst_rdata", hif.rdata, 8'h00);
    dn = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (hif.done) dn++;
    end
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (hif.done) dn++;
    end
    chk("arst_no_done", dn, 0);
    chk("arst_stay_idle", hif.busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
